// File: rtl/uart_rx_dram_loader.sv
// UART (8N1) receiver that streams bytes into DRAM at consecutive addresses
// starting at 0, then raises a sticky rx_done once NUM_BYTES are stored.
//
// Ports:
//   clk_in         system clock, rising edge
//   rst_n          asynchronous active-low reset
//   clear          synchronous active-high restart (acts like reset while high)
//   rx             asynchronous UART serial input, idles high
//   dram_address   write pointer / DRAM address
//   dram_data      last received byte
//   dram_wren      one-cycle DRAM write strobe
//   rx_done        sticky: all NUM_BYTES stored
//   framing_error  one-cycle pulse on a bad stop bit
//   rx_busy        frame in progress (not IDLE and not DONE)
module uart_rx_dram_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_BYTES    = 65536
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] dram_address,
  output logic [7:0]            dram_data,
  output logic                  dram_wren,
  output logic                  rx_done,
  output logic                  framing_error,
  output logic                  rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ferr_q, ferr_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    ferr_d    = 1'b0;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = WRITE;
            data_d  = shift_q;
          end else begin
            state_d = IDLE;
            ferr_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        cnt_d = '0;
        // Explicit wrap so NUM_BYTES below 2^ADDR_WIDTH still returns to 0.
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          state_d = IDLE;
        end
      end
      DONE: begin
        cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Clear overrides every transition, including the final WRITE.
    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      shift_d   = '0;
      data_d    = '0;
      ptr_d     = '0;
      ferr_d    = 1'b0;
      rx_meta_d = 1'b1;
      rx_s_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ptr_q     <= '0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ptr_q     <= ptr_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  assign dram_address  = ptr_q;
  assign dram_data     = data_q;
  assign dram_wren     = (state_q == WRITE);
  assign rx_done       = (state_q == DONE);
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/uart_rx_dram_loader.md
Name: uart_rx_dram_loader

Overview:
Receives a byte stream on the board Rx pin and writes each byte into DRAM at consecutive addresses, starting at 0. It drives the receiver side of the DRAM address, data and write-enable path. When the programmed number of bytes has been stored, it asserts rx_done, which the processor uses as its enable. It sits directly upstream of the top-level DRAM/processor assembly and replaces the external receiver feeding DRAM_address_receiver, DRAM_data_receiver, write_DRAM_receiver and Rx_done.

Parameters:
CLKS_PER_BIT, 434, clk_in cycles per UART bit (50 MHz / 115200); must be >= 4.
ADDR_WIDTH, 16, DRAM address width.
NUM_BYTES, 65536, bytes to load before rx_done; range 1..2^ADDR_WIDTH.

Ports:
clk_in  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous restart, level-sensitive, active-high; same effect as reset while high.
rx  input  1  UART serial in, asynchronous, idles high.
dram_address  output  ADDR_WIDTH  write pointer / DRAM address.
dram_data  output  8  byte to write.
dram_wren  output  1  one-cycle DRAM write strobe.
rx_done  output  1  sticky: all NUM_BYTES stored.
framing_error  output  1  one-cycle pulse: bad stop bit.
rx_busy  output  1  high while a frame is being received (any state other than IDLE or DONE).

Behaviour:
- Reset and clear:
  - rst_n low or clear high puts the block in IDLE.
  - All outputs go to 0. The pointer and the shift register are cleared.
  - The synchronizer flops go to 1.
- rx synchronizer: rx passes through a 2-flop synchronizer (rx_s). This adds 2 cycles of latency. All sampling uses rx_s.
- Bit counter: counts 0..CLKS_PER_BIT-1 and is reset on every state entry.
- States and transitions:
  - IDLE: go to START when rx_s is 0.
  - START: wait until count = CLKS_PER_BIT/2-1 (integer division), then re-sample rx_s.
    - rx_s = 0 goes to DATA with bit index 0.
    - rx_s = 1 is a glitch: return to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into bit[index], LSB first. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s = 1 goes to WRITE.
    - rx_s = 0 pulses framing_error for 1 cycle, discards the byte and goes to IDLE. The pointer is unchanged.
  - WRITE (exactly 1 cycle):
    - dram_wren = 1, dram_data = received byte, dram_address = current pointer.
    - On the next edge the pointer increments.
    - If the pointer was NUM_BYTES-1: the pointer wraps to 0, rx_done is set, and the state goes to DONE.
    - Otherwise the state goes to IDLE.
  - DONE: rx is ignored. rx_done is held at 1 and dram_wren at 0. The only exit is reset or clear.
- Output timing:
  - dram_data holds the last received byte between writes.
  - dram_address always shows the pointer.
  - dram_wren is never high for more than 1 consecutive cycle.
- Throughput: the WRITE cycle falls inside the stop-bit period and the mid-stop sample, so back-to-back frames with a 1-bit stop are accepted without loss.
- Mid-frame abort: clear or reset during START, DATA or STOP abandons the frame. No write occurs.
- Simultaneous events: clear has priority over every state transition, including the WRITE that would set rx_done.
- Pointer width: ADDR_WIDTH bits, wrapping modulo 2^ADDR_WIDTH. With NUM_BYTES = 2^ADDR_WIDTH the final write is to the all-ones address.

Test Plan:
Bench settings: CLKS_PER_BIT=16, NUM_BYTES=4 unless noted.
1. Reset: hold rst_n low, rx=1 -> all outputs 0, state IDLE. Release rst_n -> outputs stay 0 with rx idle.
2. Single byte 0xA5, 8N1 -> exactly one dram_wren pulse with dram_address=0 and dram_data=0xA5. The pulse occurs between 8.5 and 10 bit times after the start edge. Pointer becomes 1; rx_done stays 0.
3. Four back-to-back frames 0x01, 0x80, 0xFF, 0x3C, no idle gap -> writes at addresses 0..3 with those data. rx_done rises on the cycle after the 4th write, and dram_address returns to 0. A 5th frame produces no write.
4. Frame 0x55 with stop bit forced 0 -> framing_error pulses high for 1 cycle and there is no dram_wren. The next valid frame 0x12 is written at the same address.
5. Glitch: rx low for 4 cycles, then high -> no write and no error; the next frame is received correctly.
6. Assert clear mid-DATA of the 3rd byte, then after the 4th byte -> pointer resets to 0 with no partial write, and rx_done clears. A reload then writes from address 0 again.
